// File: rtl/dffram_2r1w_bist.sv
// Built-in self-test initiator for the 2R1W DFFRAM macro.
// Runs one full write pass on port 0, an ascending read pass on port 0 and a
// descending read pass on port 1, comparing every read word with the pattern
// {a, ~a} ^ PAT. It reports pass/fail, the mismatch count and the details of
// the first mismatch.
module dffram_2r1w_bist #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter logic [DW-1:0] PAT = 16'hA5C3
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [AW+1:0]   err_cnt,
  output logic [AW-1:0]   err_addr,
  output logic            err_port,
  output logic [DW-1:0]   err_data,
  output logic            EN0,
  output logic            EN1,
  output logic [AW-1:0]   A0,
  output logic [AW-1:0]   A1,
  output logic [DW-1:0]   Di0,
  output logic [DW/8-1:0] WE0,
  input  logic [DW-1:0]   Do0,
  input  logic [DW-1:0]   Do1
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD0,
    RD1,
    DRAIN,
    DONE
  } state_t;

  localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_ONE = 1;
  localparam logic [AW+1:0] CNT_ONE  = 1;

  state_t          state;

  logic            tag_valid;
  logic            tag_port;
  logic [AW-1:0]   tag_addr;
  logic [DW-1:0]   tag_exp;

  logic [DW-1:0]   rd_data;
  logic            mismatch;
  logic [AW-1:0]   issue_addr;

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    return {a, ~a} ^ PAT;
  endfunction

  // Address of the read currently on the pins, used to tag it for the compare
  always_comb begin
    issue_addr = EN1 ? A1 : A0;
  end

  // Compare stage: picks the port named by the tag and flags a wrong word
  always_comb begin
    rd_data  = tag_port ? Do1 : Do0;
    mismatch = tag_valid && (rd_data != tag_exp);
  end

  // One-stage tag pipeline: describes the read presented this cycle, whose data returns next cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      tag_valid <= 1'b0;
      tag_port  <= 1'b0;
      tag_addr  <= '0;
      tag_exp   <= '0;
    end else begin
      tag_valid <= (EN0 && (WE0 == '0)) || EN1;
      tag_port  <= EN1;
      tag_addr  <= issue_addr;
      tag_exp   <= pattern(issue_addr);
    end
  end

  // Sequencer: drives the registered RAM pins, status outputs and error record
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      err_addr <= '0;
      err_port <= 1'b0;
      err_data <= '0;
      EN0      <= 1'b0;
      EN1      <= 1'b0;
      A0       <= '0;
      A1       <= '0;
      Di0      <= '0;
      WE0      <= '0;
    end else begin
      if (mismatch) begin
        err_cnt <= err_cnt + CNT_ONE;
        if (err_cnt == '0) begin
          err_addr <= tag_addr;
          err_port <= tag_port;
          err_data <= rd_data;
        end
      end

      case (state)
        IDLE, DONE: begin
          EN0 <= 1'b0;
          EN1 <= 1'b0;
          WE0 <= '0;
          if (start) begin
            state    <= WRITE;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            err_addr <= '0;
            err_port <= 1'b0;
            err_data <= '0;
            EN0      <= 1'b1;
            WE0      <= '1;
            A0       <= '0;
            Di0      <= pattern('0);
          end
        end

        WRITE: begin
          if (A0 == ADDR_MAX) begin
            state <= RD0;
            WE0   <= '0;
            Di0   <= '0;
            A0    <= '0;
          end else begin
            A0  <= A0 + ADDR_ONE;
            Di0 <= pattern(A0 + ADDR_ONE);
          end
        end

        RD0: begin
          if (A0 == ADDR_MAX) begin
            state <= RD1;
            EN0   <= 1'b0;
            A0    <= '0;
            EN1   <= 1'b1;
            A1    <= ADDR_MAX;
          end else begin
            A0 <= A0 + ADDR_ONE;
          end
        end

        RD1: begin
          if (A1 == '0) begin
            state <= DRAIN;
            EN1   <= 1'b0;
          end else begin
            A1 <= A1 - ADDR_ONE;
          end
        end

        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_cnt == '0) && !mismatch;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          EN0   <= 1'b0;
          EN1   <= 1'b0;
          WE0   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dffram_2r1w_bist.sv
// Self-checking bench for dffram_2r1w_bist: behavioural 2R1W RAM with fault
// hooks, per-cycle protocol checks and a pattern-level reference model.
module tb_dffram_2r1w_bist;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int DEPTH = 256;
  localparam logic [DW-1:0] PAT = 16'hA5C3;

  logic            CLK = 1'b0;
  logic            RST;
  logic            start;
  logic            busy;
  logic            done;
  logic            pass;
  logic [AW+1:0]   err_cnt;
  logic [AW-1:0]   err_addr;
  logic            err_port;
  logic [DW-1:0]   err_data;
  logic            EN0;
  logic            EN1;
  logic [AW-1:0]   A0;
  logic [AW-1:0]   A1;
  logic [DW-1:0]   Di0;
  logic [DW/8-1:0] WE0;
  logic [DW-1:0]   Do0;
  logic [DW-1:0]   Do1;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] do0_q = '0;
  logic [DW-1:0] do1_q = '0;
  logic [AW-1:0] a0_q = '0;
  logic [AW-1:0] a1_q = '0;

  logic          f0_en = 1'b0;
  logic          f1_en = 1'b0;
  logic          stuck_en = 1'b0;
  logic [AW-1:0] f0_addr = '0;
  logic [AW-1:0] f1_addr = '0;
  logic [AW-1:0] stuck_addr = '0;
  logic [DW-1:0] f0_mask = '0;
  logic [DW-1:0] f1_mask = '0;
  logic [DW-1:0] stuck_val = '0;

  int    n_cmp = 0;
  int    n_bad = 0;
  string run_name = "reset";

  always #5 CLK = ~CLK;

  dffram_2r1w_bist #(.AW(AW), .DW(DW), .PAT(PAT)) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .err_addr(err_addr), .err_port(err_port), .err_data(err_data),
    .EN0(EN0), .EN1(EN1), .A0(A0), .A1(A1), .Di0(Di0), .WE0(WE0),
    .Do0(Do0), .Do1(Do1)
  );

  // Behavioural RAM: synchronous read, byte-enable write, optional stuck cell
  always @(posedge CLK) begin
    if (EN0) begin
      if (WE0 == 2'b11)
        mem[A0] <= (stuck_en && A0 == stuck_addr) ? stuck_val : Di0;
      do0_q <= mem[A0];
      a0_q  <= A0;
    end
    if (EN1) begin
      do1_q <= mem[A1];
      a1_q  <= A1;
    end
  end

  assign Do0 = do0_q ^ ((f0_en && a0_q == f0_addr) ? f0_mask : 16'h0000);
  assign Do1 = do1_q ^ ((f1_en && a1_q == f1_addr) ? f1_mask : 16'h0000);

  function automatic logic [DW-1:0] exp_word(input int a);
    logic [7:0] b;
    b = a[7:0];
    return {b, ~b} ^ PAT;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s/%s: got %0h want %0h", run_name, tag, got, want);
    end
  endtask

  // Reference: what each of the 512 reads returns, in issue order
  task automatic refResult(output int cnt, output int faddr, output int fport, output int fdata);
    int a;
    logic [DW-1:0] stored;
    logic [DW-1:0] obs;
    cnt = 0; faddr = 0; fport = 0; fdata = 0;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < DEPTH; k++) begin
        a = (p == 0) ? k : DEPTH - 1 - k;
        stored = (stuck_en && a == int'(stuck_addr)) ? stuck_val : exp_word(a);
        if (p == 0)
          obs = stored ^ ((f0_en && a == int'(f0_addr)) ? f0_mask : 16'h0000);
        else
          obs = stored ^ ((f1_en && a == int'(f1_addr)) ? f1_mask : 16'h0000);
        if (obs != exp_word(a)) begin
          if (cnt == 0) begin
            faddr = a; fport = p; fdata = int'(obs);
          end
          cnt++;
        end
      end
    end
  endtask

  task automatic checkResults();
    int cnt, fa, fp, fd;
    refResult(cnt, fa, fp, fd);
    checkOutput("done", 32'(done), 1);
    checkOutput("pass", 32'(pass), (cnt == 0) ? 1 : 0);
    checkOutput("err_cnt", 32'(err_cnt), cnt);
    checkOutput("err_addr", 32'(err_addr), fa);
    checkOutput("err_port", 32'(err_port), fp);
    checkOutput("err_data", 32'(err_data), fd);
  endtask

  // Pulses start, then follows the run cycle by cycle from the start edge
  task automatic applyStimulus(input int extra_start_cyc, input int rst_cyc);
    int  done_cyc;
    int  viol;
    logic e_en0, e_en1, e_we;
    done_cyc = 0;
    viol = 0;
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    for (int c = 1; c <= 900; c++) begin
      @(negedge CLK);
      start = (c == extra_start_cyc);
      if (rst_cyc != 0 && c == rst_cyc + 1) begin
        checkOutput("rst_en0", 32'(EN0), 0);
        checkOutput("rst_en1", 32'(EN1), 0);
        checkOutput("rst_we0", 32'(WE0), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        RST = 1'b0;
        return;
      end
      if (c == rst_cyc) RST = 1'b1;
      if (c == 1) begin
        checkOutput("clr_err_cnt", 32'(err_cnt), 0);
        checkOutput("clr_err_addr", 32'(err_addr), 0);
        checkOutput("clr_err_port", 32'(err_port), 0);
        checkOutput("clr_err_data", 32'(err_data), 0);
        checkOutput("clr_pass", 32'(pass), 0);
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      e_en0 = (c <= 512);
      e_en1 = (c >= 513 && c <= 768);
      e_we  = (c <= 256);
      if (EN0 !== e_en0) viol++;
      if (EN1 !== e_en1) viol++;
      if ((WE0 != 2'b00) != e_we) viol++;
      if (e_we && WE0 != 2'b11) viol++;
      if (e_en0 && A0 != 8'((c - 1) % 256)) viol++;
      if (e_we && Di0 != exp_word(c - 1)) viol++;
      if (e_en1 && A1 != 8'(768 - c)) viol++;
      if (EN0 && EN1) viol++;
      if (busy !== 1'b1) viol++;
    end
    start = 1'b0;
    checkOutput("done_cycle", done_cyc, 770);
    checkOutput("protocol", viol, 0);
    checkOutput("busy_at_done", 32'(busy), 0);
    checkOutput("idle_en", 32'({EN0, EN1, WE0}), 0);
  endtask

  initial begin
    RST = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("busy", 32'(busy), 0);
    checkOutput("done", 32'(done), 0);
    checkOutput("pass", 32'(pass), 0);
    checkOutput("err_cnt", 32'(err_cnt), 0);
    checkOutput("err_addr", 32'(err_addr), 0);
    checkOutput("err_port", 32'(err_port), 0);
    checkOutput("err_data", 32'(err_data), 0);
    checkOutput("en", 32'({EN0, EN1}), 0);
    checkOutput("we0", 32'(WE0), 0);
    checkOutput("addr", 32'({A0, A1}), 0);
    checkOutput("di0", 32'(Di0), 0);
    RST = 1'b0;

    run_name = "clean";
    applyStimulus(0, 0);
    checkResults();
    checkOutput("mem0", 32'(mem[0]), 32'(exp_word(0)));
    checkOutput("mem255", 32'(mem[255]), 32'(exp_word(255)));
    checkOutput("mem_mid", 32'(mem[8'h9B]), 32'(exp_word(8'h9B)));

    run_name = "extra_start";
    applyStimulus(300, 0);
    checkResults();

    run_name = "mid_reset";
    applyStimulus(0, 400);

    run_name = "after_reset";
    applyStimulus(0, 0);
    checkResults();

    run_name = "do0_bit3";
    f0_en = 1'b1; f0_addr = 8'h40; f0_mask = 16'h0008;
    applyStimulus(0, 0);
    checkResults();
    checkOutput("err_data_abs", 32'(err_data), 32'(exp_word(8'h40) ^ 16'h0008));

    run_name = "restart";
    f0_en = 1'b0;
    applyStimulus(0, 0);
    checkResults();

    run_name = "stuck_plus_do1";
    stuck_en = 1'b1; stuck_addr = 8'h10; stuck_val = exp_word(8'h10) ^ 16'h0100;
    f1_en = 1'b1; f1_addr = 8'hF0; f1_mask = 16'h8000;
    applyStimulus(0, 0);
    checkResults();
    checkOutput("err_cnt_abs", 32'(err_cnt), 3);

    for (int r = 0; r < 4; r++) begin
      run_name = $sformatf("random%0d", r);
      f0_en = 1'($urandom_range(0, 1));
      f1_en = 1'($urandom_range(0, 1));
      stuck_en = 1'($urandom_range(0, 1));
      f0_addr = 8'($urandom_range(0, 255));
      f1_addr = 8'($urandom_range(0, 255));
      stuck_addr = 8'($urandom_range(0, 255));
      f0_mask = 16'h0001 << $urandom_range(0, 15);
      f1_mask = 16'h0001 << $urandom_range(0, 15);
      stuck_val = exp_word(int'(stuck_addr)) ^ (16'h0001 << $urandom_range(0, 15));
      applyStimulus(0, 0);
      checkResults();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
